prim_pad_attr_ctrl: RTL and testbench

PRIM_PAD_ATTR_CTRL -- requirements
Module: prim_pad_attr_ctrl

---
 rtl/prim_pad_attr_ctrl.sv | 177 +++++++++++++++++
 tb/tb_prim_pad_attr_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/prim_pad_attr_ctrl.sv
// ============================================================================
// Module  : prim_pad_attr_ctrl
// Brief   : Per-pad attribute/output-enable register bank with a
//           break-before-make sequence. Optional macro: PRIM_PAD_ATTR_CTRL_LOCK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prim_pad_attr_ctrl #(
  parameter int NPads      = 4,
  parameter int AttrDw     = 10,
  parameter int TurnCycles = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [3:0]               addr_i,
  input  logic [AttrDw:0]          wdata_i,
`ifdef PRIM_PAD_ATTR_CTRL_LOCK_EN
  input  logic [NPads-1:0]         lock_i,
`endif
  input  logic [AttrDw-1:0]        warl_i,
  output logic                     gnt_o,
  output logic                     rvalid_o,
  output logic [AttrDw:0]          rdata_o,
  output logic                     err_o,
  output logic [NPads*AttrDw-1:0]  attr_o,
  output logic [NPads-1:0]         oe_o,
  output logic                     busy_o
);

  localparam logic [3:0] c_turn_last = 4'(TurnCycles - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [3:0]          r_pad;
  logic [AttrDw-1:0]   r_new_attr;
  logic                r_new_oe;
  logic [AttrDw-1:0]   r_attr [NPads];
  logic [NPads-1:0]    r_oe;
  logic                r_rvalid;
  logic                r_err;
  logic [AttrDw:0]     r_rdata;

  logic [31:0]         w_addr32;
  logic [31:0]         w_pad32;
  logic                w_in_range;
  logic [AttrDw-1:0]   w_masked;
  logic [AttrDw-1:0]   w_cur_attr;
  logic                w_cur_oe;
  logic                w_cur_lock;
  logic                w_fast;
  logic [NPads-1:0]    w_lock_vec;

`ifdef PRIM_PAD_ATTR_CTRL_LOCK_EN
  assign w_lock_vec = lock_i;
`else
  assign w_lock_vec = '0;
`endif

  assign w_addr32   = {28'd0, addr_i};
  assign w_pad32    = {28'd0, r_pad};
  assign w_in_range = (w_addr32 < 32'(NPads));
  assign w_masked   = wdata_i[AttrDw-1:0] & warl_i;

  always_comb begin
    w_cur_attr = '0;
    w_cur_oe   = 1'b0;
    w_cur_lock = 1'b0;
    for (int n = 0; n < NPads; n++) begin
      if (w_addr32 == 32'(n)) begin
        w_cur_attr = r_attr[n];
        w_cur_oe   = r_oe[n];
        w_cur_lock = w_lock_vec[n];
      end
    end
  end

  // A pad that is not driving, or whose attribute does not change, can update at once.
  assign w_fast = (w_masked == w_cur_attr) || !w_cur_oe;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_pad      <= '0;
      r_new_attr <= '0;
      r_new_oe   <= 1'b0;
      r_oe       <= '0;
      r_rvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      for (int n = 0; n < NPads; n++) begin
        r_attr[n] <= '0;
      end
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            if (!we_i) begin
              r_rvalid <= 1'b1;
              r_err    <= !w_in_range;
              r_rdata  <= w_in_range ? {w_cur_oe, w_cur_attr} : '0;
            end else if (!w_in_range || w_cur_lock) begin
              r_rvalid <= 1'b1;
              r_err    <= 1'b1;
            end else if (w_fast) begin
              r_rvalid <= 1'b1;
              for (int n = 0; n < NPads; n++) begin
                if (w_addr32 == 32'(n)) begin
                  r_attr[n] <= w_masked;
                  r_oe[n]   <= wdata_i[AttrDw];
                end
              end
            end else begin
              r_state    <= ST_DRAIN;
              r_cnt      <= c_turn_last;
              r_pad      <= addr_i;
              r_new_attr <= w_masked;
              r_new_oe   <= wdata_i[AttrDw];
              for (int n = 0; n < NPads; n++) begin
                if (w_addr32 == 32'(n)) begin
                  r_oe[n] <= 1'b0;
                end
              end
            end
          end
        end
        ST_DRAIN: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_APPLY;
            for (int n = 0; n < NPads; n++) begin
              if (w_pad32 == 32'(n)) begin
                r_attr[n] <= r_new_attr;
              end
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_APPLY: begin
          r_state  <= ST_IDLE;
          r_rvalid <= 1'b1;
          for (int n = 0; n < NPads; n++) begin
            if (w_pad32 == 32'(n)) begin
              r_oe[n] <= r_new_oe;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NPads; g++) begin : g_pack
    assign attr_o[g*AttrDw +: AttrDw] = r_attr[g];
  end

  assign gnt_o    = req_i && (r_state == ST_IDLE);
  assign busy_o   = (r_state != ST_IDLE);
  assign oe_o     = r_oe;
  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;
  assign rdata_o  = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_prim_pad_attr_ctrl.sv
// ============================================================================
// Module  : tb_prim_pad_attr_ctrl
// Brief   : Directed and random checks of prim_pad_attr_ctrl against a
//           transaction-level pad model. Honours PRIM_PAD_ATTR_CTRL_LOCK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prim_pad_attr_ctrl;

  localparam int P_NPADS = 4;
  localparam int P_ADW   = 10;
  localparam int P_TC    = 2;

  logic                      clk_i = 1'b0;
  logic                      rst_ni;
  logic                      req_i;
  logic                      we_i;
  logic [3:0]                addr_i;
  logic [P_ADW:0]            wdata_i;
  logic [P_ADW-1:0]          warl_i;
  logic                      gnt_o;
  logic                      rvalid_o;
  logic [P_ADW:0]            rdata_o;
  logic                      err_o;
  logic [P_NPADS*P_ADW-1:0]  attr_o;
  logic [P_NPADS-1:0]        oe_o;
  logic                      busy_o;
  logic [P_NPADS-1:0]        m_lock;
`ifdef PRIM_PAD_ATTR_CTRL_LOCK_EN
  logic [P_NPADS-1:0]        lock_i;
  assign lock_i = m_lock;
`endif

  prim_pad_attr_ctrl #(
    .NPads     (P_NPADS),
    .AttrDw    (P_ADW),
    .TurnCycles(P_TC)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
`ifdef PRIM_PAD_ATTR_CTRL_LOCK_EN
    .lock_i  (lock_i),
`endif
    .warl_i  (warl_i),
    .gnt_o   (gnt_o),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o),
    .attr_o  (attr_o),
    .oe_o    (oe_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [P_ADW-1:0]   m_attr [P_NPADS];
  logic [P_NPADS-1:0] m_oe;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < P_NPADS; n++) m_attr[n] = '0;
    m_oe = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_attr"},   64'(attr_o),   64'd0);
    chk({tag, "_oe"},     64'(oe_o),     64'd0);
    chk({tag, "_rdata"},  64'(rdata_o),  64'd0);
    chk({tag, "_rvalid"}, 64'(rvalid_o), 64'd0);
    chk({tag, "_err"},    64'(err_o),    64'd0);
    chk({tag, "_busy"},   64'(busy_o),   64'd0);
  endtask

  // One transaction, called at a falling edge; checks every cycle until completion.
  task automatic do_op(input logic w, input logic [3:0] a, input logic [P_ADW:0] wd);
    int                       ai;
    int                       lat;
    bit                       in_r, locked, err_e, slow;
    logic [P_ADW-1:0]         na;
    logic                     no;
    logic [P_ADW:0]           rd_e;
    logic [P_NPADS*P_ADW-1:0] ea;
    logic [P_NPADS-1:0]       eo;
    in_r   = int'(a) < P_NPADS;
    ai     = in_r ? int'(a) : 0;
    na     = wd[P_ADW-1:0] & warl_i;
    no     = wd[P_ADW];
    locked = in_r && m_lock[ai];
    err_e  = !in_r || (w && locked);
    rd_e   = (!w && in_r) ? {m_oe[ai], m_attr[ai]} : '0;
    slow   = w && !err_e && (na != m_attr[ai]) && m_oe[ai];
    lat    = slow ? P_TC + 2 : 1;
    req_i = 1'b1; we_i = w; addr_i = a; wdata_i = wd;
    #1 chk("gnt_idle", 64'(gnt_o), 64'd1);
    @(posedge clk_i);
    #1;
    if (!slow) req_i = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk_i);
      for (int n = 0; n < P_NPADS; n++) ea[n*P_ADW +: P_ADW] = m_attr[n];
      eo = m_oe;
      if (w && !err_e) begin
        if (!slow) begin
          ea[ai*P_ADW +: P_ADW] = na;
          eo[ai] = no;
        end else begin
          eo[ai] = (k == lat) ? no : 1'b0;
          if (k > P_TC) ea[ai*P_ADW +: P_ADW] = na;
        end
      end
      chk("attr",   64'(attr_o),   64'(ea));
      chk("oe",     64'(oe_o),     64'(eo));
      chk("rvalid", 64'(rvalid_o), 64'(k == lat));
      chk("busy",   64'(busy_o),   64'(slow && (k < lat)));
      if (k < lat) chk("gnt_held", 64'(gnt_o), 64'd0);
      if (k == lat) begin
        chk("err", 64'(err_o), 64'(err_e));
        if (!w) chk("rdata", 64'(rdata_o), 64'(rd_e));
      end
    end
    req_i = 1'b0;
    if (w && !err_e) begin
      m_attr[ai] = na;
      m_oe[ai]   = no;
    end
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    warl_i = '1; m_lock = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk_all_zero("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);

    do_op(1'b0, 4'd2, '0);
    warl_i = 10'h003;
    do_op(1'b1, 4'd1, {1'b1, 10'h3FF});
    do_op(1'b1, 4'd1, {1'b1, 10'h001});
    do_op(1'b0, 4'd1, '0);
    do_op(1'b1, 4'd7, {1'b1, 10'h155});
    do_op(1'b0, 4'd9, '0);

`ifdef PRIM_PAD_ATTR_CTRL_LOCK_EN
    m_lock = 4'b0010;
    do_op(1'b1, 4'd1, {1'b0, 10'h002});
    m_lock = '0;
`endif

    // Reset lands in the middle of a drain; nothing may complete afterwards.
    req_i = 1'b1; we_i = 1'b1; addr_i = 4'd1; wdata_i = {1'b1, 10'h002};
    @(posedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0; req_i = 1'b0;
    @(posedge clk_i);
    #1 chk_all_zero("rst_drain");
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1 chk("rst_drain_no_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_drain_idle", 64'(busy_o), 64'd0);
    @(negedge clk_i);

    for (int i = 0; i < 80; i++) begin
      warl_i = ($urandom_range(0, 3) == 0) ? 10'($urandom) : '1;
`ifdef PRIM_PAD_ATTR_CTRL_LOCK_EN
      m_lock = 4'($urandom);
`endif
      do_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 11'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
